// File: rtl/dds_cfg_pkg.sv
// Shared definitions for the DDS configuration frame parser: parser states,
// frame header bytes, per-channel byte layout and the channel config record.
package dds_cfg_pkg;

    // Parser states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_H1,
        ST_H2,
        ST_H3,
        ST_LEN_H,
        ST_LEN_L,
        ST_PAYLOAD,
        ST_SKIP
    } state_t;

    // Frame header: 00 00 01 01
    localparam logic [7:0] HDR_B0 = 8'h00;
    localparam logic [7:0] HDR_B1 = 8'h00;
    localparam logic [7:0] HDR_B2 = 8'h01;
    localparam logic [7:0] HDR_B3 = 8'h01;

    // Payload layout: NUM_CHAN blocks of CHAN_BYTES bytes
    localparam int NUM_CHAN   = 2;
    localparam int CHAN_BYTES = 12;
    localparam int IDX_W      = 5;   // wide enough for a 0..23 payload index

    // Byte offsets of each field inside one channel block (big-endian fields)
    localparam int OFF_CTRL   = 0;
    localparam int OFF_FRQ    = 1;
    localparam int OFF_AMP    = 4;
    localparam int OFF_OFFSET = 6;
    localparam int OFF_PHA    = 8;
    localparam int OFF_DUTY   = 10;

    // One channel's live configuration ('type' is a keyword, hence wave_type)
    typedef struct packed {
        logic        run;
        logic [2:0]  wave_type;
        logic [23:0] frq;
        logic [15:0] amp;
        logic [15:0] offset;
        logic [15:0] pha;
        logic [15:0] duty;
    } dds_chan_cfg_t;

endpackage

// File: rtl/dds_cfg_chan_regs.sv
// Per-channel shadow/live register pair. Payload bytes land in the shadow
// bank one at a time; a commit copies the whole shadow bank to the live bank
// in a single edge so the DDS core never sees a half-written configuration.
module dds_cfg_chan_regs
    import dds_cfg_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [IDX_W-1:0]     i_idx,     // byte index local to this channel
    input  logic [7:0]           i_byte,
    input  logic                 i_we,
    input  logic                 i_clr,     // drop a partially collected frame
    input  logic                 i_commit,
    output dds_chan_cfg_t        o_cfg
);

    localparam logic [IDX_W-1:0] I_CTRL  = IDX_W'(OFF_CTRL);
    localparam logic [IDX_W-1:0] I_FRQ0  = IDX_W'(OFF_FRQ);
    localparam logic [IDX_W-1:0] I_FRQ1  = IDX_W'(OFF_FRQ + 1);
    localparam logic [IDX_W-1:0] I_FRQ2  = IDX_W'(OFF_FRQ + 2);
    localparam logic [IDX_W-1:0] I_AMP0  = IDX_W'(OFF_AMP);
    localparam logic [IDX_W-1:0] I_AMP1  = IDX_W'(OFF_AMP + 1);
    localparam logic [IDX_W-1:0] I_OFS0  = IDX_W'(OFF_OFFSET);
    localparam logic [IDX_W-1:0] I_OFS1  = IDX_W'(OFF_OFFSET + 1);
    localparam logic [IDX_W-1:0] I_PHA0  = IDX_W'(OFF_PHA);
    localparam logic [IDX_W-1:0] I_PHA1  = IDX_W'(OFF_PHA + 1);
    localparam logic [IDX_W-1:0] I_DUTY0 = IDX_W'(OFF_DUTY);
    localparam logic [IDX_W-1:0] I_DUTY1 = IDX_W'(OFF_DUTY + 1);

    dds_chan_cfg_t shadow_reg;
    dds_chan_cfg_t live_reg;

    // Shadow bank byte writes and atomic shadow-to-live commit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow_reg <= '0;
            live_reg   <= '0;
        end else begin
            if (i_clr) begin
                shadow_reg <= '0;
            end else if (i_we) begin
                case (i_idx)
                    // upper nibble of the control byte is reserved
                    I_CTRL: begin
                        shadow_reg.run       <= i_byte[3];
                        shadow_reg.wave_type <= i_byte[2:0];
                    end
                    I_FRQ0:  shadow_reg.frq[23:16]   <= i_byte;
                    I_FRQ1:  shadow_reg.frq[15:8]    <= i_byte;
                    I_FRQ2:  shadow_reg.frq[7:0]     <= i_byte;
                    I_AMP0:  shadow_reg.amp[15:8]    <= i_byte;
                    I_AMP1:  shadow_reg.amp[7:0]     <= i_byte;
                    I_OFS0:  shadow_reg.offset[15:8] <= i_byte;
                    I_OFS1:  shadow_reg.offset[7:0]  <= i_byte;
                    I_PHA0:  shadow_reg.pha[15:8]    <= i_byte;
                    I_PHA1:  shadow_reg.pha[7:0]     <= i_byte;
                    I_DUTY0: shadow_reg.duty[15:8]   <= i_byte;
                    I_DUTY1: shadow_reg.duty[7:0]    <= i_byte;
                    default: ;
                endcase
            end
            if (i_commit) begin
                live_reg <= shadow_reg;
            end
        end
    end

    assign o_cfg = live_reg;

endmodule

// File: rtl/dds_cfg_ctrl.sv
// Configuration frame parser for the two-channel DDS. Hunts for the
// 00 00 01 01 header in the UART byte stream, checks the length field,
// collects the payload into per-channel shadow registers and commits both
// channels together. Bad lengths and stalled frames are counted and dropped.
module dds_cfg_ctrl
    import dds_cfg_pkg::*;
#(
    parameter int P_PAYLOAD_LEN = 24,
    parameter int P_TIMEOUT_CYC = 50000
)
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_dds1_run,
    output logic [2:0]  o_dds1_type,
    output logic [23:0] o_dds1_frq,
    output logic [15:0] o_dds1_amp,
    output logic [15:0] o_dds1_offset,
    output logic [15:0] o_dds1_pha,
    output logic [15:0] o_dds1_duty,
    output logic        o_dds2_run,
    output logic [2:0]  o_dds2_type,
    output logic [23:0] o_dds2_frq,
    output logic [15:0] o_dds2_amp,
    output logic [15:0] o_dds2_offset,
    output logic [15:0] o_dds2_pha,
    output logic [15:0] o_dds2_duty,
    output logic        o_cfg_update,
    output logic        o_busy,
    output logic [7:0]  o_err_cnt
);

    localparam int TO_W = $clog2(P_TIMEOUT_CYC + 1);

    state_t             state_reg,    state_next;
    logic [IDX_W-1:0]   idx_reg,      idx_next;
    logic [7:0]         len_hi_reg,   len_hi_next;
    logic [15:0]        skip_cnt_reg, skip_cnt_next;
    logic [TO_W-1:0]    to_cnt_reg,   to_cnt_next;
    logic [7:0]         err_cnt_reg;
    logic               commit_reg,   commit_next;
    logic               update_reg;
    logic               err_inc;
    logic               shadow_we;
    logic               shadow_clr;
    logic [15:0]        len_full;

    dds_chan_cfg_t      chan_cfg [NUM_CHAN];

    assign len_full = {len_hi_reg, i_rx_data};

    // Next-state, counter and strobe decode for the frame parser
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        len_hi_next   = len_hi_reg;
        skip_cnt_next = skip_cnt_reg;
        to_cnt_next   = to_cnt_reg;
        commit_next   = 1'b0;
        err_inc       = 1'b0;
        shadow_we     = 1'b0;
        shadow_clr    = 1'b0;

        if (i_rx_valid) begin
            // a byte in this cycle always wins over an expiring timeout
            to_cnt_next = '0;
            case (state_reg)
                ST_IDLE: begin
                    if (i_rx_data == HDR_B0) state_next = ST_H1;
                end
                ST_H1: begin
                    state_next = (i_rx_data == HDR_B1) ? ST_H2 : ST_IDLE;
                end
                ST_H2: begin
                    // extra leading zeros keep us aligned on the last two
                    if (i_rx_data == HDR_B2)      state_next = ST_H3;
                    else if (i_rx_data == HDR_B1) state_next = ST_H2;
                    else                          state_next = ST_IDLE;
                end
                ST_H3: begin
                    // "00" here may be the start of a fresh header
                    if (i_rx_data == HDR_B3)      state_next = ST_LEN_H;
                    else if (i_rx_data == HDR_B0) state_next = ST_H1;
                    else                          state_next = ST_IDLE;
                end
                ST_LEN_H: begin
                    len_hi_next = i_rx_data;
                    state_next  = ST_LEN_L;
                end
                ST_LEN_L: begin
                    if (len_full == 16'(P_PAYLOAD_LEN)) begin
                        idx_next   = '0;
                        state_next = ST_PAYLOAD;
                    end else if (len_full == 16'd0) begin
                        err_inc    = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        skip_cnt_next = len_full;
                        state_next    = ST_SKIP;
                    end
                end
                ST_PAYLOAD: begin
                    shadow_we = 1'b1;
                    if (idx_reg == IDX_W'(P_PAYLOAD_LEN - 1)) begin
                        commit_next = 1'b1;
                        idx_next    = '0;
                        state_next  = ST_IDLE;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
                ST_SKIP: begin
                    skip_cnt_next = skip_cnt_reg - 16'd1;
                    if (skip_cnt_reg == 16'd1) begin
                        err_inc    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (state_reg != ST_IDLE) begin
            if (to_cnt_reg == TO_W'(P_TIMEOUT_CYC - 1)) begin
                to_cnt_next = '0;
                err_inc     = 1'b1;
                shadow_clr  = 1'b1;
                state_next  = ST_IDLE;
            end else begin
                to_cnt_next = to_cnt_reg + 1'b1;
            end
        end
    end

    // Parser state, counters and registered strobes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            len_hi_reg   <= '0;
            skip_cnt_reg <= '0;
            to_cnt_reg   <= '0;
            err_cnt_reg  <= '0;
            commit_reg   <= 1'b0;
            update_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            len_hi_reg   <= len_hi_next;
            skip_cnt_reg <= skip_cnt_next;
            to_cnt_reg   <= to_cnt_next;
            commit_reg   <= commit_next;
            // the pulse lines up with the live banks loading from commit_reg
            update_reg   <= commit_reg;
            if (err_inc && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    // One register pair per channel; each sees the payload index rebased to its block
    for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
        logic [IDX_W-1:0] rel_idx;
        logic             chan_we;

        // unsigned wrap makes indices below this block land far above CHAN_BYTES
        assign rel_idx = idx_reg - IDX_W'(gi * CHAN_BYTES);
        assign chan_we = shadow_we && (rel_idx < IDX_W'(CHAN_BYTES));

        dds_cfg_chan_regs u_regs (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_idx    (rel_idx),
            .i_byte   (i_rx_data),
            .i_we     (chan_we),
            .i_clr    (shadow_clr),
            .i_commit (commit_reg),
            .o_cfg    (chan_cfg[gi])
        );
    end

    assign o_dds1_run    = chan_cfg[0].run;
    assign o_dds1_type   = chan_cfg[0].wave_type;
    assign o_dds1_frq    = chan_cfg[0].frq;
    assign o_dds1_amp    = chan_cfg[0].amp;
    assign o_dds1_offset = chan_cfg[0].offset;
    assign o_dds1_pha    = chan_cfg[0].pha;
    assign o_dds1_duty   = chan_cfg[0].duty;
    assign o_dds2_run    = chan_cfg[1].run;
    assign o_dds2_type   = chan_cfg[1].wave_type;
    assign o_dds2_frq    = chan_cfg[1].frq;
    assign o_dds2_amp    = chan_cfg[1].amp;
    assign o_dds2_offset = chan_cfg[1].offset;
    assign o_dds2_pha    = chan_cfg[1].pha;
    assign o_dds2_duty   = chan_cfg[1].duty;

    assign o_cfg_update  = update_reg;
    assign o_busy        = (state_reg != ST_IDLE);
    assign o_err_cnt     = err_cnt_reg;

endmodule

// File: tb/tb_dds_cfg_ctrl.sv
// Directed-plus-random bench for dds_cfg_ctrl. Frames are assembled from
// field values with plain arithmetic; the expected outputs are simply the
// field values of the last complete, length-correct frame.
module tb_dds_cfg_ctrl;

    localparam int PAYLOAD_LEN = 24;
    localparam int TIMEOUT     = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        dds1_run, dds2_run;
    logic [2:0]  dds1_type, dds2_type;
    logic [23:0] dds1_frq, dds2_frq;
    logic [15:0] dds1_amp, dds1_offset, dds1_pha, dds1_duty;
    logic [15:0] dds2_amp, dds2_offset, dds2_pha, dds2_duty;
    logic        cfg_update, busy;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    dds_cfg_ctrl #(.P_PAYLOAD_LEN(PAYLOAD_LEN), .P_TIMEOUT_CYC(TIMEOUT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_dds1_run(dds1_run), .o_dds1_type(dds1_type), .o_dds1_frq(dds1_frq),
        .o_dds1_amp(dds1_amp), .o_dds1_offset(dds1_offset), .o_dds1_pha(dds1_pha),
        .o_dds1_duty(dds1_duty),
        .o_dds2_run(dds2_run), .o_dds2_type(dds2_type), .o_dds2_frq(dds2_frq),
        .o_dds2_amp(dds2_amp), .o_dds2_offset(dds2_offset), .o_dds2_pha(dds2_pha),
        .o_dds2_duty(dds2_duty),
        .o_cfg_update(cfg_update), .o_busy(busy), .o_err_cnt(err_cnt)
    );

    typedef struct {
        bit        run;
        bit [2:0]  wtype;
        bit [23:0] frq;
        bit [15:0] amp;
        bit [15:0] offset;
        bit [15:0] pha;
        bit [15:0] duty;
    } tcfg_t;

    tcfg_t      exp_cfg [2];
    tcfg_t      zero_cfg;
    tcfg_t      ca, cb, cc, cd;
    int         exp_err;
    int         exp_pulses;
    int         pulse_cnt = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] q [$];

    // Count update pulses mid-cycle, away from the edge
    always @(negedge clk) if (cfg_update === 1'b1) pulse_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cfg(input string tag);
        chk({tag, " ch1 run"},    32'(dds1_run),    32'(exp_cfg[0].run));
        chk({tag, " ch1 type"},   32'(dds1_type),   32'(exp_cfg[0].wtype));
        chk({tag, " ch1 frq"},    32'(dds1_frq),    32'(exp_cfg[0].frq));
        chk({tag, " ch1 amp"},    32'(dds1_amp),    32'(exp_cfg[0].amp));
        chk({tag, " ch1 offset"}, 32'(dds1_offset), 32'(exp_cfg[0].offset));
        chk({tag, " ch1 pha"},    32'(dds1_pha),    32'(exp_cfg[0].pha));
        chk({tag, " ch1 duty"},   32'(dds1_duty),   32'(exp_cfg[0].duty));
        chk({tag, " ch2 run"},    32'(dds2_run),    32'(exp_cfg[1].run));
        chk({tag, " ch2 type"},   32'(dds2_type),   32'(exp_cfg[1].wtype));
        chk({tag, " ch2 frq"},    32'(dds2_frq),    32'(exp_cfg[1].frq));
        chk({tag, " ch2 amp"},    32'(dds2_amp),    32'(exp_cfg[1].amp));
        chk({tag, " ch2 offset"}, 32'(dds2_offset), 32'(exp_cfg[1].offset));
        chk({tag, " ch2 pha"},    32'(dds2_pha),    32'(exp_cfg[1].pha));
        chk({tag, " ch2 duty"},   32'(dds2_duty),   32'(exp_cfg[1].duty));
    endtask

    function automatic tcfg_t rand_cfg();
        tcfg_t c;
        c.run    = 1'($urandom);
        c.wtype  = 3'($urandom);
        c.frq    = 24'($urandom);
        c.amp    = 16'($urandom);
        c.offset = 16'($urandom);
        c.pha    = 16'($urandom);
        c.duty   = 16'($urandom);
        return c;
    endfunction

    function automatic void push_hdr(input bit [15:0] len);
        q.push_back(8'h00); q.push_back(8'h00);
        q.push_back(8'h01); q.push_back(8'h01);
        q.push_back(len[15:8]); q.push_back(len[7:0]);
    endfunction

    // Serialise one channel block; rsv fills the ignored control-byte nibble
    function automatic void push_chan(input tcfg_t c, input bit [3:0] rsv);
        q.push_back({rsv, c.run, c.wtype});
        q.push_back(c.frq[23:16]);   q.push_back(c.frq[15:8]);   q.push_back(c.frq[7:0]);
        q.push_back(c.amp[15:8]);    q.push_back(c.amp[7:0]);
        q.push_back(c.offset[15:8]); q.push_back(c.offset[7:0]);
        q.push_back(c.pha[15:8]);    q.push_back(c.pha[7:0]);
        q.push_back(c.duty[15:8]);   q.push_back(c.duty[7:0]);
    endfunction

    // Drive one byte for exactly one sampling edge; returns 1 ns after that edge
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Send the queued bytes with up to max_gap idle cycles between them
    task automatic send_q(input int max_gap);
        int n;
        for (int i = 0; i < q.size(); i++) begin
            send_byte(q[i]);
            if (max_gap > 0 && i != q.size() - 1) begin
                n = $urandom_range(max_gap, 0);
                if (n > 0) begin
                    repeat (n) @(posedge clk);
                    #1;
                end
            end
        end
        q.delete();
    endtask

    // Called right after the last payload byte was sampled: outputs must still
    // hold the old configuration, then switch together with a one-cycle pulse.
    task automatic expect_commit(input string tag, input tcfg_t n0, input tcfg_t n1);
        chk({tag, " update early"}, 32'(cfg_update), 32'd0);
        check_cfg({tag, " pre"});
        @(posedge clk);
        #1;
        exp_cfg[0] = n0;
        exp_cfg[1] = n1;
        exp_pulses++;
        chk({tag, " update"}, 32'(cfg_update), 32'd1);
        check_cfg(tag);
        @(posedge clk);
        #1;
        chk({tag, " update end"}, 32'(cfg_update), 32'd0);
        chk({tag, " pulses"}, 32'(pulse_cnt), 32'(exp_pulses));
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " err"}, 32'(err_cnt), 32'(exp_err));
    endtask

    initial begin
        zero_cfg   = '{default: 0};
        exp_cfg[0] = zero_cfg;
        exp_cfg[1] = zero_cfg;
        exp_err    = 0;
        exp_pulses = 0;
        rst_n      = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_cfg("reset");
        chk("reset update", 32'(cfg_update), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset err", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed reference frame
        ca = '{run: 1, wtype: 0, frq: 24'h4C4B40, amp: 16'd1500, offset: 0, pha: 0, duty: 16'd200};
        cb = '{run: 1, wtype: 0, frq: 24'h2625A0, amp: 16'd1500, offset: 0, pha: 0, duty: 16'd800};
        push_hdr(16'(PAYLOAD_LEN));
        push_chan(ca, 4'h0);
        push_chan(cb, 4'h0);
        send_q(0);
        expect_commit("t1 directed", ca, cb);
        $display("t1 directed frame done");

        // Extra leading zero exercises the H2 self-loop
        ca = rand_cfg();
        cb = rand_cfg();
        q.push_back(8'h00);
        push_hdr(16'(PAYLOAD_LEN));
        push_chan(ca, 4'($urandom));
        push_chan(cb, 4'($urandom));
        send_q(2);
        expect_commit("t2 h2 loop", ca, cb);
        $display("t2 h2 self-loop frame done");

        // Wrong length is skipped whole, then a good frame lands
        push_hdr(16'd22);
        for (int i = 0; i < 22; i++) q.push_back(8'($urandom));
        send_q(1);
        exp_err++;
        chk("t3 skip err", 32'(err_cnt), 32'(exp_err));
        chk("t3 skip busy", 32'(busy), 32'd0);
        chk("t3 skip pulses", 32'(pulse_cnt), 32'(exp_pulses));
        check_cfg("t3 skip hold");
        ca = rand_cfg();
        cb = rand_cfg();
        push_hdr(16'(PAYLOAD_LEN));
        push_chan(ca, 4'($urandom));
        push_chan(cb, 4'($urandom));
        send_q(0);
        expect_commit("t3 after skip", ca, cb);
        $display("t3 skip then valid frame done");

        // Noise, then two frames with the second header right after the first payload
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < 3; k++) q.push_back(8'($urandom_range(255, 2)));
            ca = rand_cfg(); cb = rand_cfg();
            cc = rand_cfg(); cd = rand_cfg();
            push_hdr(16'(PAYLOAD_LEN));
            push_chan(ca, 4'($urandom));
            push_chan(cb, 4'($urandom));
            push_hdr(16'(PAYLOAD_LEN));
            push_chan(cc, 4'($urandom));
            push_chan(cd, 4'($urandom));
            send_q((it == 0) ? 0 : 3);
            exp_cfg[0] = ca;
            exp_cfg[1] = cb;
            exp_pulses++;
            expect_commit($sformatf("t4 b2b %0d", it), cc, cd);
            $display("t4 back-to-back pair %0d done", it);
        end

        // Stall mid-payload until the timeout drops the frame
        push_hdr(16'(PAYLOAD_LEN));
        for (int i = 0; i < 10; i++) q.push_back(8'($urandom));
        send_q(0);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        chk("t5 busy before timeout", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        exp_err++;
        chk("t5 busy after timeout", 32'(busy), 32'd0);
        chk("t5 timeout err", 32'(err_cnt), 32'(exp_err));
        chk("t5 timeout pulses", 32'(pulse_cnt), 32'(exp_pulses));
        check_cfg("t5 timeout hold");
        $display("t5 timeout done");

        // Asynchronous reset in the middle of the payload
        push_hdr(16'(PAYLOAD_LEN));
        for (int i = 0; i < 15; i++) q.push_back(8'($urandom));
        send_q(0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cfg[0] = zero_cfg;
        exp_cfg[1] = zero_cfg;
        exp_err    = 0;
        check_cfg("t6 async reset");
        chk("t6 reset busy", 32'(busy), 32'd0);
        chk("t6 reset err", 32'(err_cnt), 32'd0);
        chk("t6 reset update", 32'(cfg_update), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ca = rand_cfg();
        cb = rand_cfg();
        push_hdr(16'(PAYLOAD_LEN));
        push_chan(ca, 4'($urandom));
        push_chan(cb, 4'($urandom));
        send_q(1);
        expect_commit("t6 after reset", ca, cb);
        $display("t6 reset mid-frame done");

        // Zero-length frames drive the error counter into saturation
        for (int i = 0; i < 300; i++) begin
            push_hdr(16'd0);
            send_q(0);
            if (exp_err < 255) exp_err++;
            if (i == 199) chk("t7 err at 200", 32'(err_cnt), 32'(exp_err));
        end
        chk("t7 err saturated", 32'(err_cnt), 32'd255);
        chk("t7 busy", 32'(busy), 32'd0);
        chk("t7 pulses", 32'(pulse_cnt), 32'(exp_pulses));
        check_cfg("t7 hold");
        $display("t7 saturation done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_cfg_ctrl.md
# dds_cfg_ctrl

Byte-stream frame parser and configuration controller for the two-channel DDS. It sits between the UART DMA receive side (user RX byte stream) and both DDS cores. It recognises the PC configuration frame, validates its length, and collects both channel parameter sets in shadow registers. It then updates both channels' live configuration atomically with a one-cycle update strobe.

## Interface
- P_PAYLOAD_LEN, 24: required payload byte count (2 channels × 12 bytes).
- P_TIMEOUT_CYC, 50000: idle clocks between bytes, mid-frame, before the frame is aborted.
- i_clk  in  1  system clock; single clock domain.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle qualifier for i_rx_data. There is no backpressure; every valid byte is consumed.
- o_dds1_run / o_dds2_run  out  1  channel enable.
- o_dds1_type / o_dds2_type  out  3  waveform select.
- o_dds1_frq / o_dds2_frq  out  24  frequency word.
- o_dds1_amp, o_dds1_offset, o_dds1_pha, o_dds1_duty (and the dds2 equivalents)  out  16 each.
- o_cfg_update  out  1  one-cycle pulse, high in the cycle the new configuration first appears on the outputs.
- o_busy  out  1  high whenever state ≠ IDLE.
- o_err_cnt  out  8  saturating count of dropped frames.

## Operation
- Frame format: header 00 00 01 01, then LEN_H, LEN_L, then the payload. The payload is channel 1 (12 bytes) followed by channel 2 (12 bytes).
- Channel byte order, all fields big-endian:
  - b0 = {reserved[3:0], run, type[2:0]}; the reserved bits are ignored.
  - b1–b3 = frq[23:0]
  - b4–b5 = amp
  - b6–b7 = offset
  - b8–b9 = pha
  - b10–b11 = duty
- States: IDLE, H1, H2, H3, LEN_H, LEN_L, PAYLOAD, SKIP.
- Header matching. Transitions are taken on i_rx_valid only:
  - IDLE: 00 → H1; any other byte stays in IDLE.
  - H1: 00 → H2; any other byte → IDLE.
  - H2: 01 → H3; 00 stays in H2; any other byte → IDLE.
  - H3: 01 → LEN_H; 00 → H1; any other byte → IDLE.
- Length handling:
  - LEN_H captures len[15:8]; LEN_L captures len[7:0].
  - If len == P_PAYLOAD_LEN → PAYLOAD with byte index cleared.
  - If len == 0 → IDLE and o_err_cnt increments.
  - Any other len → SKIP with the down-counter loaded with len.
- PAYLOAD:
  - Each byte is written into the shadow field selected by the byte index (0–23), and the index increments.
  - At index 23: the byte is written, all shadow fields copy to the outputs on the next edge, o_cfg_update pulses, and the state returns to IDLE.
- SKIP: each byte decrements the counter. When the counter reaches 0 → IDLE and o_err_cnt increments.
- Timeout:
  - The inter-byte counter clears on every i_rx_valid and runs in every state except IDLE.
  - When it reaches P_TIMEOUT_CYC → IDLE, o_err_cnt increments, and the shadow contents are discarded. Outputs are unchanged.
  - If a valid byte arrives in the same cycle, the byte is processed and no timeout fires.
- o_err_cnt saturates at 255.
- Outputs only ever change through a complete, length-correct frame. A partial frame never modifies any output.

## Timing
- Reset: all outputs are 0 (run = 0, so both DDS channels are idle), o_cfg_update = 0, o_busy = 0, o_err_cnt = 0, state = IDLE.
- Latency: outputs and o_cfg_update are registered one cycle after the clock edge that samples the 24th payload byte. The update is atomic: all fields of both channels change on the same edge.
- Back-to-back frames:
  - A header byte may arrive in the cycle immediately after the final payload byte; it is parsed normally.
  - o_cfg_update may then pulse again as early as the next frame's completion.
- Reset asserted mid-frame: the block returns to IDLE immediately and asynchronously, and every output takes its reset value.

## Structure
- The shared package `dds_cfg_pkg` holds:
  - the state enum
  - the header byte constants
  - the per-channel field byte offsets (0, 1, 4, 6, 8, 10)
  - the channel byte count, 12
  - a `dds_chan_cfg_t` struct {run, type, frq, amp, offset, pha, duty}.
- One sub-module, `dds_cfg_chan_regs`, is instantiated twice. It contains:
  - the shadow register bank, written from (local index, byte, we)
  - the live register bank, loaded on commit
  - outputs as `dds_chan_cfg_t`.
- The top level contains the FSM, the index, skip and timeout counters, and the error counter.

## Test plan
- Send the valid frame: len 24; ch1 run=1, type=0, frq 0x4C4B40, amp 1500, offset 0, pha 0, duty 200; ch2 run=1, type=0, frq 0x2625A0, amp 1500, duty 800 → a single o_cfg_update pulse one cycle after the last byte, with all fields matching.
- Send the prefix 00 00 00 01 01 followed by a valid length and payload → the frame is accepted through the H2 self-loop.
- Send len = 22 followed by 22 bytes, then a valid frame → the first frame is skipped, o_err_cnt = 1, and the second frame is applied. Outputs are unchanged before the second frame completes.
- Stop after 10 payload bytes and idle for P_TIMEOUT_CYC cycles → o_busy falls, o_err_cnt increments, outputs keep their previous values, and no update pulse occurs.
- Assert i_rst_n low at payload byte 15 → outputs go to 0 immediately. A subsequent full frame is applied correctly.
- Send 300 frames with len = 0 → o_err_cnt saturates at 255.
